// File: rtl/mult_div_if.sv
// mult_div_if: command/result bundle between Control and the multiply/divide unit.
//   multStart, divStart : one-cycle start pulses from Control
//   a, b                : 32-bit operands (dividend/multiplicand, divisor/multiplier)
//   hi, lo              : result (product [63:32]/[31:0], or remainder/quotient)
//   busy, done, div0    : status; done is a one-cycle pulse, div0 accompanies done
// master = Control side, slave = mult_div side.
interface mult_div_if;
  logic        multStart;
  logic        divStart;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  modport master (
    output multStart, divStart, a, b,
    input  hi, lo, busy, done, div0
  );

  modport slave (
    input  multStart, divStart, a, b,
    output hi, lo, busy, done, div0
  );
endinterface

// File: rtl/mult_div.sv
// mult_div: iterative signed 32x32 multiplier (radix-2 Booth) and optional
// signed restoring divider. Result lands in hi/lo 33 cycles after the start
// is sampled; done pulses for one cycle.
//   clk   : system clock, all state changes on posedge
//   reset : synchronous active-high reset
//   bus   : mult_div_if.slave (multStart, divStart, a, b, hi, lo, busy, done, div0)
// Macro MULT_DIV_DIVIDE_EN: when defined, builds the divider (DIV state,
// divStart handling, div0). When undefined, divStart is ignored and div0 is 0.
module mult_div (
  input  logic      clk,
  input  logic      reset,
  mult_div_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
`ifdef MULT_DIV_DIVIDE_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            steps_done_q, steps_done_d;  // all 32 steps done; next cycle publishes
  logic [XLEN:0]   acc_hi_q, acc_hi_d;          // Booth A / division partial remainder
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;          // Booth Q / division quotient bits
  logic            acc_x_q, acc_x_d;            // Booth q[-1]
  logic [XLEN-1:0] m_q, m_d;                    // multiplicand, or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d, done_q, done_d, div0_q, div0_d;

  // Booth add/subtract followed by arithmetic shift of {A,Q,q-1}
  logic [XLEN:0] m_ext, booth_sum;
  always_comb begin
    m_ext = {m_q[XLEN-1], m_q};
    case ({acc_lo_q[0], acc_x_q})
      2'b01:   booth_sum = acc_hi_q + m_ext;
      2'b10:   booth_sum = acc_hi_q - m_ext;
      default: booth_sum = acc_hi_q;
    endcase
  end

`ifdef MULT_DIV_DIVIDE_EN
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [XLEN-1:0] a_mag, b_mag, quot_fix, rem_fix;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  // Restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    a_mag    = bus.a[XLEN-1] ? (~bus.a + XLEN'(1)) : bus.a;
    b_mag    = bus.b[XLEN-1] ? (~bus.b + XLEN'(1)) : bus.b;
    rem_sh   = {acc_hi_q[XLEN-1:0], acc_lo_q[XLEN-1]};
    trial    = {1'b0, rem_sh} - {2'b00, m_q};
    quot_fix = neg_q_q ? (~acc_lo_q + XLEN'(1)) : acc_lo_q;
    rem_fix  = neg_r_q ? (~acc_hi_q[XLEN-1:0] + XLEN'(1)) : acc_hi_q[XLEN-1:0];
  end
`else
  logic div_start_unused;
  assign div_start_unused = bus.divStart;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    steps_done_d = steps_done_q;
    acc_hi_d     = acc_hi_q;
    acc_lo_d     = acc_lo_q;
    acc_x_d      = acc_x_q;
    m_d          = m_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    div0_d       = 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
    neg_q_d      = neg_q_q;
    neg_r_d      = neg_r_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.multStart) begin
          m_d          = bus.a;
          acc_hi_d     = '0;
          acc_lo_d     = bus.b;
          acc_x_d      = 1'b0;
          cnt_d        = '0;
          steps_done_d = 1'b0;
          state_d      = S_MULT;
          busy_d       = 1'b1;
        end
`ifdef MULT_DIV_DIVIDE_EN
        else if (bus.divStart) begin
          if (bus.b == '0) begin
            // Divide by zero: report immediately, results untouched
            state_d = S_DONE;
            done_d  = 1'b1;
            div0_d  = 1'b1;
          end else begin
            m_d          = b_mag;
            acc_hi_d     = '0;
            acc_lo_d     = a_mag;
            acc_x_d      = 1'b0;
            neg_q_d      = bus.a[XLEN-1] ^ bus.b[XLEN-1];
            neg_r_d      = bus.a[XLEN-1];
            cnt_d        = '0;
            steps_done_d = 1'b0;
            state_d      = S_DIV;
            busy_d       = 1'b1;
          end
        end
`endif
      end
      S_MULT: begin
        if (steps_done_q) begin
          hi_d    = acc_hi_q[XLEN-1:0];
          lo_d    = acc_lo_q;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          acc_hi_d     = {booth_sum[XLEN], booth_sum[XLEN:1]};
          acc_lo_d     = {booth_sum[0], acc_lo_q[XLEN-1:1]};
          acc_x_d      = acc_lo_q[0];
          cnt_d        = cnt_q + CNT_W'(1);
          steps_done_d = (cnt_q == LAST_STEP);
          busy_d       = 1'b1;
        end
      end
`ifdef MULT_DIV_DIVIDE_EN
      S_DIV: begin
        if (steps_done_q) begin
          hi_d    = rem_fix;
          lo_d    = quot_fix;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (!trial[XLEN+1]) begin
            acc_hi_d = trial[XLEN:0];
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_sh;
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d        = cnt_q + CNT_W'(1);
          steps_done_d = (cnt_q == LAST_STEP);
          busy_d       = 1'b1;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      steps_done_q <= 1'b0;
      acc_hi_q     <= '0;
      acc_lo_q     <= '0;
      acc_x_q      <= 1'b0;
      m_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div0_q       <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      steps_done_q <= steps_done_d;
      acc_hi_q     <= acc_hi_d;
      acc_lo_q     <= acc_lo_d;
      acc_x_q      <= acc_x_d;
      m_q          <= m_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      div0_q       <= div0_d;
`ifdef MULT_DIV_DIVIDE_EN
      neg_q_q      <= neg_q_d;
      neg_r_q      <= neg_r_d;
`endif
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed self-checking bench for mult_div.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mult_div;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_if bus();

  mult_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   passed = 0;
  int   lat;
  int   pulses;
  logic busy0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive a one-cycle start pulse; busy0 holds busy right after the sampling edge
  task automatic start(input logic ms, input logic ds, input logic [31:0] av, input logic [31:0] bv);
    bus.multStart = ms;
    bus.divStart  = ds;
    bus.a         = av;
    bus.b         = bv;
    tick();
    bus.multStart = 1'b0;
    bus.divStart  = 1'b0;
    busy0         = bus.busy;
  endtask

  // Cycles after the sampling edge until done; 60 means it never came
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.multStart = 1'b0;
    bus.divStart  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    tick();
    tick();
    check("rst_hi",   bus.hi, 32'd0);
    check("rst_lo",   bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_div0", 32'(bus.div0), 32'd0);
    reset = 1'b0;
    tick();

    // 7 * -3 = -21
    start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    check("mul1_busy", 32'(busy0), 32'd1);
    wait_done(lat);
    check("mul1_lat",  32'(lat), 32'd33);
    check("mul1_hi",   bus.hi, 32'hFFFF_FFFF);
    check("mul1_lo",   bus.lo, 32'hFFFF_FFEB);
    check("mul1_div0", 32'(bus.div0), 32'd0);
    check("mul1_busy_at_done", 32'(bus.busy), 32'd0);
    tick();
    check("mul1_done_1cyc", 32'(bus.done), 32'd0);
    check("mul1_hi_hold",   bus.hi, 32'hFFFF_FFFF);

    // Both starts together: multiply wins
    start(1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat);
    check("both_lat", 32'(lat), 32'd33);
    check("both_hi",  bus.hi, 32'd1);
    check("both_lo",  bus.lo, 32'd0);
    check("both_div0", 32'(bus.div0), 32'd0);
    tick();

    // Extreme operands
    start(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat);
    check("mmin_hi", bus.hi, 32'h4000_0000);
    check("mmin_lo", bus.lo, 32'h0000_0000);
    tick();
    start(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    check("mneg1_hi", bus.hi, 32'h0000_0000);
    check("mneg1_lo", bus.lo, 32'h0000_0001);
    tick();
    start(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_done(lat);
    check("mmax_hi", bus.hi, 32'hC000_0000);
    check("mmax_lo", bus.lo, 32'h8000_0000);
    tick();

`ifdef MULT_DIV_DIVIDE_EN
    // -7 / 2 -> q=-3, r=-1
    start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div1_busy", 32'(busy0), 32'd1);
    wait_done(lat);
    check("div1_lat", 32'(lat), 32'd33);
    check("div1_lo",  bus.lo, 32'hFFFF_FFFD);
    check("div1_hi",  bus.hi, 32'hFFFF_FFFF);
    check("div1_div0", 32'(bus.div0), 32'd0);
    tick();
    // Most negative / -1 wraps to itself
    start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("divmin_lo", bus.lo, 32'h8000_0000);
    check("divmin_hi", bus.hi, 32'h0000_0000);
    tick();
    // 100 / -7 -> q=-14, r=2
    start(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done(lat);
    check("div3_lo", bus.lo, 32'hFFFF_FFF2);
    check("div3_hi", bus.hi, 32'h0000_0002);
    tick();
    // -100 / -7 -> q=14, r=-2
    start(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done(lat);
    check("div4_lo", bus.lo, 32'h0000_000E);
    check("div4_hi", bus.hi, 32'hFFFF_FFFE);
    tick();
    // Divide by zero: done+div0 right after the sampling edge, hi/lo kept
    start(1'b0, 1'b1, 32'd5, 32'd0);
    check("dz_done", 32'(bus.done), 32'd1);
    check("dz_div0", 32'(bus.div0), 32'd1);
    check("dz_busy", 32'(bus.busy), 32'd0);
    check("dz_lo",   bus.lo, 32'h0000_000E);
    check("dz_hi",   bus.hi, 32'hFFFF_FFFE);
    tick();
    check("dz_done_clr", 32'(bus.done), 32'd0);
    check("dz_div0_clr", 32'(bus.div0), 32'd0);
    check("dz_lo_hold",  bus.lo, 32'h0000_000E);
`else
    // Divider absent: divStart has no effect
    start(1'b0, 1'b1, 32'd5, 32'd0);
    check("nodiv_busy", 32'(busy0), 32'd0);
    pulses = 0;
    repeat (40) begin
      if (bus.done === 1'b1 || bus.div0 === 1'b1) pulses++;
      tick();
    end
    check("nodiv_pulses", 32'(pulses), 32'd0);
    check("nodiv_hi", bus.hi, 32'hC000_0000);
    check("nodiv_lo", bus.lo, 32'h8000_0000);
`endif

    // Reset in the middle of a multiply
    start(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi",   bus.hi, 32'd0);
    check("abort_lo",   bus.lo, 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    start(1'b1, 1'b0, 32'd3, 32'd5);
    wait_done(lat);
    check("after_abort_lat", 32'(lat), 32'd33);
    check("after_abort_lo",  bus.lo, 32'd15);
    check("after_abort_hi",  bus.hi, 32'd0);
    tick();

    // Second start while busy is dropped
    start(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (5) tick();
    bus.a         = 32'd100;
    bus.b         = 32'd100;
    bus.multStart = 1'b1;
    tick();
    bus.multStart = 1'b0;
    pulses = 0;
    repeat (45) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("busy_ign_pulses", 32'(pulses), 32'd1);
    check("busy_ign_lo", bus.lo, 32'd42);
    check("busy_ign_hi", bus.hi, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on posedge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: multStart  input  1  one-cycle pulse from Control; requests signed multiply a*b.
REQ-004 SHALL have port: divStart  input  1  one-cycle pulse from Control; requests signed divide a/b.
REQ-005 SHALL have port: a  input  32  operand A (dividend / multiplicand), taken from register A.
REQ-006 SHALL have port: b  input  32  operand B (divisor / multiplier), taken from register B.
REQ-007 SHALL have port: hi  output  32  product bits [63:32], or division remainder.
REQ-008 SHALL have port: lo  output  32  product bits [31:0], or division quotient.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress (states MULT, DIV).
REQ-010 SHALL have port: done  output  1  one-cycle pulse; hi/lo valid, or a div0 event has occurred.
REQ-011 SHALL have port: div0  output  1  high together with done when a divide had b == 0.

Function
REQ-012 SHALL implement states IDLE, MULT, DIV, DONE, plus a 5-bit iteration counter.
REQ-013 SHALL, in IDLE, sample multStart/divStart on posedge: latch a and b, clear the counter, enter MULT or DIV.
REQ-014 SHALL give multStart priority when multStart and divStart are both high.
REQ-015 SHALL ignore multStart and divStart while busy or while in DONE (no queuing).
REQ-016 SHALL, in MULT, perform one radix-2 Booth step per cycle for 32 cycles, then load hi:lo with the signed 64-bit product and enter DONE.
REQ-017 SHALL, in DIV, perform one restoring-division step on the operand magnitudes per cycle for 32 cycles, then apply signs and enter DONE.
REQ-018 SHALL set quotient sign = a[31] XOR b[31] and remainder sign = a[31] (truncating division); lo = quotient, hi = remainder.
REQ-019 SHALL, for a = 0x80000000 and b = 0xFFFFFFFF, produce lo = 0x80000000 and hi = 0, with no exception.
REQ-020 SHALL, on divStart with b == 0, enter DONE on the next edge with div0 = 1, leave hi/lo unchanged, and skip iteration.
REQ-021 SHALL hold done = 1 for exactly one cycle (state DONE), then return to IDLE; div0 SHALL be high only in that same cycle.
REQ-022 SHALL have a latency of 33 cycles from the start-sampling edge to done high, for both multiply and divide (b != 0); divide-by-zero latency is 1 cycle.
REQ-023 SHALL hold hi/lo stable at all times except on the edge entering DONE, so Control can read MFHI/MFLO at any time afterwards.

Reset
REQ-024 SHALL, when reset = 1 at posedge, abort any operation, enter IDLE, clear the counter, and set hi = 0, lo = 0, busy = 0, done = 0, div0 = 0.
REQ-025 SHALL give reset priority over multStart/divStart on the same edge; a start asserted with reset SHALL be lost.

Configuration
REQ-026 SHALL compile the divider only when macro MULT_DIV_DIVIDE_EN is defined.
REQ-027 SHALL, with MULT_DIV_DIVIDE_EN defined, behave as in REQ-017 through REQ-022.
REQ-028 SHALL, without MULT_DIV_DIVIDE_EN, omit the DIV state and divider datapath, ignore divStart, and tie div0 to 0; multiply behaviour SHALL be unchanged.

Verification
REQ-029 SHALL cover: multStart, a = 7, b = -3 (0xFFFFFFFD) -> done 33 cycles later, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, div0 = 0.
REQ-030 SHALL cover: divStart, a = -7, b = 2 -> done 33 cycles later, lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
REQ-031 SHALL cover: divStart, a = 5, b = 0 -> done and div0 high one cycle later for exactly one cycle; hi/lo keep their prior values.
REQ-032 SHALL cover: multStart and divStart in the same cycle with a = 0x00010000, b = 0x00010000 -> multiply performed, hi = 1, lo = 0.
REQ-033 SHALL cover: reset asserted at cycle 10 of a multiply -> next cycle busy = 0, hi = lo = 0, no done pulse; a following multStart completes normally.
REQ-034 SHALL cover: a second multStart during busy -> ignored, with exactly one done pulse and the first operation's result.
